// File: rtl/rtclock_regs_if.sv
// ---------------------------------------------------------------------------
// rtclock_regs_if
// AXI4-Lite bus bundle between the interconnect and the RTC register file.
//   Write address : awaddr, awvalid (m->s), awready (s->m)
//   Write data    : wdata, wstrb, wvalid (m->s), wready (s->m)
//   Write resp    : bresp, bvalid (s->m), bready (m->s)
//   Read address  : araddr, arvalid (m->s), arready (s->m)
//   Read data     : rdata, rresp, rvalid (s->m), rready (m->s)
// ---------------------------------------------------------------------------
interface rtclock_regs_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/rtclock_regs.sv
// ---------------------------------------------------------------------------
// rtclock_regs
// AXI4-Lite control/status register file for the real-time clock core.
// Ports:
//   clk                      sole clock
//   reset                    synchronous, active-high
//   s_axi                    AXI4-Lite slave (rtclock_regs_if.slave)
//   id_reg, version_reg      constant identity values (RO)
//   ip2cpu_flip_reg          FLIP readback from the core
//   cpu2ip_flip_reg          last value written to FLIP
//   control_reg              bit0 pps_enable, bit1 pps_select
//   sec_config_reg           48-bit seconds preload {HI[15:0], LO}
//   sec_state_reg            live 48-bit seconds counter
//   last_period_pps_reg      ns counted in the last PPS period
//   corrected_delta_pps_reg  per-clock ns increment, 4.28 fixed point
// Register map (byte offsets from C_BASE_ADDRESS):
//   0x00 ID  0x04 VERSION  0x08 FLIP  0x0C CONTROL  0x10/0x14 SEC_CONFIG
//   0x18/0x1C SEC_STATE  0x20 LAST_PERIOD_PPS  0x24 CORRECTED_DELTA_PPS
// ---------------------------------------------------------------------------
module rtclock_regs #(
    parameter int          C_S_AXI_DATA_WIDTH      = 32,
    parameter int          C_S_AXI_ADDR_WIDTH      = 12,
    parameter logic [31:0] C_BASE_ADDRESS          = 32'h0,
    parameter logic [31:0] C_CORRECTED_DELTA_RESET = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    rtclock_regs_if.slave        s_axi,
    input  logic [31:0]          id_reg,
    input  logic [31:0]          version_reg,
    input  logic [31:0]          ip2cpu_flip_reg,
    output logic [31:0]          cpu2ip_flip_reg,
    output logic [31:0]          control_reg,
    output logic [47:0]          sec_config_reg,
    input  logic [47:0]          sec_state_reg,
    input  logic [31:0]          last_period_pps_reg,
    output logic [31:0]          corrected_delta_pps_reg
);
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W = AW - 2;

    localparam logic [AW-1:0] BASE_OFF = C_BASE_ADDRESS[AW-1:0];

    localparam logic [IDX_W-1:0] R_ID       = IDX_W'(0);
    localparam logic [IDX_W-1:0] R_VERSION  = IDX_W'(1);
    localparam logic [IDX_W-1:0] R_FLIP     = IDX_W'(2);
    localparam logic [IDX_W-1:0] R_CONTROL  = IDX_W'(3);
    localparam logic [IDX_W-1:0] R_CFG_LO   = IDX_W'(4);
    localparam logic [IDX_W-1:0] R_CFG_HI   = IDX_W'(5);
    localparam logic [IDX_W-1:0] R_STATE_LO = IDX_W'(6);
    localparam logic [IDX_W-1:0] R_STATE_HI = IDX_W'(7);
    localparam logic [IDX_W-1:0] R_PERIOD   = IDX_W'(8);
    localparam logic [IDX_W-1:0] R_DELTA    = IDX_W'(9);

    // Byte-lane merge: lanes with a clear strobe keep their old value.
    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                            input logic [15:0] new_v,
                                            input logic [1:0]  strb);
        logic [15:0] r;
        for (int b = 0; b < 2; b++)
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    // Handshake / channel state
    logic                          wr_ready_q;
    logic                          bvalid_q;
    logic                          arready_q;
    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

    // Register storage
    logic [31:0] flip_q;
    logic [31:0] ctrl_q;
    logic [31:0] cfg_lo_q;
    logic [15:0] cfg_hi_q;
    logic [31:0] delta_q;
    logic [15:0] state_hi_snap_q;

    logic                          wr_fire;
    logic                          rd_fire;
    logic [IDX_W-1:0]              wr_idx;
    logic [IDX_W-1:0]              rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;

    // Word index after removing the base; the byte-lane bits drop out in the shift.
    assign wr_idx = IDX_W'((s_axi.awaddr - BASE_OFF) >> 2);
    assign rd_idx = IDX_W'((s_axi.araddr - BASE_OFF) >> 2);

    // READY is only raised once both AW and W are present, so a single
    // registered ready serves both channels and they always complete together.
    assign wr_fire = wr_ready_q & s_axi.awvalid & s_axi.wvalid;
    assign rd_fire = arready_q & s_axi.arvalid;

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            R_ID:       rd_mux = id_reg;
            R_VERSION:  rd_mux = version_reg;
            R_FLIP:     rd_mux = ip2cpu_flip_reg;
            R_CONTROL:  rd_mux = ctrl_q;
            R_CFG_LO:   rd_mux = cfg_lo_q;
            R_CFG_HI:   rd_mux = {16'h0, cfg_hi_q};
            R_STATE_LO: rd_mux = sec_state_reg[31:0];
            R_STATE_HI: rd_mux = {16'h0, state_hi_snap_q};
            R_PERIOD:   rd_mux = last_period_pps_reg;
            R_DELTA:    rd_mux = delta_q;
            default:    rd_mux = '0;
        endcase
    end

    // Write channel: ready pulse, then response held until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            wr_ready_q <= ~wr_ready_q & s_axi.awvalid & s_axi.wvalid & ~bvalid_q;
            if (wr_fire)
                bvalid_q <= 1'b1;
            else if (s_axi.bready)
                bvalid_q <= 1'b0;
        end
    end

    // Read channel: data captured at the address handshake, held until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= ~arready_q & s_axi.arvalid & ~rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Register update; a read on the same edge sees the pre-write value
    always_ff @(posedge clk) begin
        if (reset) begin
            flip_q          <= '0;
            ctrl_q          <= '0;
            cfg_lo_q        <= '0;
            cfg_hi_q        <= '0;
            delta_q         <= C_CORRECTED_DELTA_RESET;
            state_hi_snap_q <= '0;
        end else begin
            if (wr_fire) begin
                case (wr_idx)
                    R_FLIP:    flip_q   <= merge32(flip_q, s_axi.wdata, s_axi.wstrb);
                    R_CONTROL: ctrl_q   <= merge32(ctrl_q, s_axi.wdata, s_axi.wstrb);
                    R_CFG_LO:  cfg_lo_q <= merge32(cfg_lo_q, s_axi.wdata, s_axi.wstrb);
                    R_CFG_HI:  cfg_hi_q <= merge16(cfg_hi_q, s_axi.wdata[15:0], s_axi.wstrb[1:0]);
                    R_DELTA:   delta_q  <= merge32(delta_q, s_axi.wdata, s_axi.wstrb);
                    default:   ;
                endcase
            end
            // Reading the low word freezes the high word so a LO-then-HI pair is coherent.
            if (rd_fire && rd_idx == R_STATE_LO)
                state_hi_snap_q <= sec_state_reg[47:32];
        end
    end

    assign s_axi.awready = wr_ready_q;
    assign s_axi.wready  = wr_ready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    assign cpu2ip_flip_reg         = flip_q;
    assign control_reg             = ctrl_q;
    assign sec_config_reg          = {cfg_hi_q, cfg_lo_q};
    assign corrected_delta_pps_reg = delta_q;
endmodule

// File: tb/tb_rtclock_regs.sv
// ---------------------------------------------------------------------------
// tb_rtclock_regs
// Directed bench for the RTC AXI4-Lite register file. Read expectations are
// queued when a read is issued and popped when RVALID is seen.
// ---------------------------------------------------------------------------
module tb_rtclock_regs;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] id_reg = 32'h1234_5678;
    logic [31:0] version_reg = 32'h0001_0000;
    logic [31:0] ip2cpu_flip_reg = 32'hA5A5_0F0F;
    logic [31:0] cpu2ip_flip_reg;
    logic [31:0] control_reg;
    logic [47:0] sec_config_reg;
    logic [47:0] sec_state_reg = 48'h0;
    logic [31:0] last_period_pps_reg = 32'h3B9A_CA00;
    logic [31:0] corrected_delta_pps_reg;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    // Output values captured just before / just after the last write handshake edge
    logic [31:0] ctrl_before_hs;
    logic [31:0] ctrl_after_hs;

    rtclock_regs_if bus ();

    rtclock_regs dut (
        .clk                     (clk),
        .reset                   (reset),
        .s_axi                   (bus),
        .id_reg                  (id_reg),
        .version_reg             (version_reg),
        .ip2cpu_flip_reg         (ip2cpu_flip_reg),
        .cpu2ip_flip_reg         (cpu2ip_flip_reg),
        .control_reg             (control_reg),
        .sec_config_reg          (sec_config_reg),
        .sec_state_reg           (sec_state_reg),
        .last_period_pps_reg     (last_period_pps_reg),
        .corrected_delta_pps_reg (corrected_delta_pps_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s timeout waiting for DUT", tag);
    endtask

    // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW; 0: together
    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead);
        bit ok;
        int n;
        n = (lead < 0) ? -lead : lead;
        @(negedge clk);
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        if (lead >= 0) bus.awvalid = 1'b1;
        if (lead <= 0) bus.wvalid  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("wr_ready_early", {62'b0, bus.awready, bus.wready}, 64'h0);
        end
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.awready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            timeout("wr_awready");
        end else begin
            chk("wr_wready", bus.wready, 1);
        end
        ctrl_before_hs = control_reg;
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge clk);
        ctrl_after_hs = control_reg;
        chk("wr_bvalid", bus.bvalid, 1);
        chk("wr_ready_pulse", bus.awready, 0);
        @(negedge clk);
        chk("wr_bvalid_hold", bus.bvalid, 1);
        chk("wr_bresp", bus.bresp, 0);
        bus.bready = 1'b1;
        @(posedge clk);
        #1;
        bus.bready = 1'b0;
        @(negedge clk);
        chk("wr_bvalid_drop", bus.bvalid, 0);
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp, input string tag);
        bit          ok;
        logic [31:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout({tag, "_arready"});
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.rvalid) begin
                ok = 1'b1;
                break;
            end
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (!ok) begin
            timeout({t, "_rvalid"});
        end else begin
            chk(t, bus.rdata, e);
            chk({t, "_rresp"}, bus.rresp, 0);
            @(negedge clk);
            chk({t, "_hold"}, {31'b0, bus.rvalid, bus.rdata}, {31'b0, 1'b1, e});
        end
        bus.rready = 1'b1;
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
        @(negedge clk);
        chk({t, "_rvalid_drop"}, bus.rvalid, 0);
    endtask

    initial begin
        bit ok;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_handshake", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_resp", {bus.bresp, bus.rresp}, 0);
        chk("rst_flip", cpu2ip_flip_reg, 0);
        chk("rst_control", control_reg, 0);
        chk("rst_sec_config", sec_config_reg, 0);
        chk("rst_delta", corrected_delta_pps_reg, 32'h8000_0000);

        // Identity and reset-value readback
        axi_read(12'h000, 32'h1234_5678, "rd_id");
        axi_read(12'h004, 32'h0001_0000, "rd_version");
        axi_read(12'h024, 32'h8000_0000, "rd_delta_rst");

        // CONTROL with AW three cycles ahead of W
        axi_write(12'h00C, 32'h0000_0003, 4'hF, 3);
        chk("ctrl_before_hs", ctrl_before_hs, 0);
        chk("ctrl_after_hs", ctrl_after_hs, 3);
        axi_read(12'h00C, 32'h0000_0003, "rd_control");

        // 48-bit seconds preload; HI upper half is discarded
        axi_write(12'h010, 32'hDEAD_BEEF, 4'hF, 0);
        axi_write(12'h014, 32'hFFFF_0012, 4'hF, 0);
        chk("sec_config", sec_config_reg, 48'h0012_DEAD_BEEF);
        axi_read(12'h014, 32'h0000_0012, "rd_cfg_hi");
        axi_read(12'h010, 32'hDEAD_BEEF, "rd_cfg_lo");

        // Byte-strobed write to CORRECTED_DELTA
        axi_write(12'h024, 32'h1234_56AA, 4'b0001, 0);
        chk("delta_partial", corrected_delta_pps_reg, 32'h8000_00AA);

        // Coherent seconds snapshot
        sec_state_reg = 48'h0001_FFFF_FFFF;
        axi_read(12'h018, 32'hFFFF_FFFF, "rd_state_lo");
        sec_state_reg = 48'h0002_0000_0000;
        axi_read(12'h01C, 32'h0000_0001, "rd_state_hi_snap");
        axi_read(12'h020, 32'h3B9A_CA00, "rd_last_period");

        // FLIP and an unmapped write
        axi_write(12'h008, 32'h0000_CAFE, 4'hF, 0);
        chk("flip_out", cpu2ip_flip_reg, 32'h0000_CAFE);
        axi_write(12'h03C, 32'h0000_CAFE, 4'hF, 0);
        chk("unmapped_flip", cpu2ip_flip_reg, 32'h0000_CAFE);
        chk("unmapped_control", control_reg, 3);
        chk("unmapped_sec_config", sec_config_reg, 48'h0012_DEAD_BEEF);
        chk("unmapped_delta", corrected_delta_pps_reg, 32'h8000_00AA);
        axi_read(12'h03C, 32'h0, "rd_unmapped");
        axi_read(12'h008, 32'hA5A5_0F0F, "rd_flip");

        // Low address bits are ignored
        axi_read(12'h00F, 32'h0000_0003, "rd_control_unaligned");

        // W ahead of AW by two cycles
        axi_write(12'h00C, 32'h0000_0001, 4'hF, -2);
        chk("ctrl_w_first", control_reg, 1);

        // Read and write of CONTROL handshaking on the same edge
        fork
            axi_write(12'h00C, 32'h0000_0002, 4'hF, 0);
            axi_read(12'h00C, 32'h0000_0001, "rd_control_prewrite");
        join
        chk("ctrl_after_collide", control_reg, 2);

        // Reset landing on the write handshake edge aborts the write
        @(negedge clk);
        bus.awaddr  = 12'h00C;
        bus.wdata   = 32'h0000_00FF;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.awready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("abort_awready");
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge clk);
        chk("abort_handshake", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 0);
        chk("abort_control", control_reg, 0);
        chk("abort_flip", cpu2ip_flip_reg, 0);
        chk("abort_sec_config", sec_config_reg, 0);
        chk("abort_delta", corrected_delta_pps_reg, 32'h8000_0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        axi_read(12'h00C, 32'h0, "rd_control_after_abort");
        axi_read(12'h01C, 32'h0, "rd_snap_after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
